stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Time-base and control stage directly upstream of SPI_driver.
- Counts centiseconds, seconds and minutes in BCD on the 100 Hz tick, under start/stop and lap/clear push-buttons.
- Drives the six BCD digit buses that SPI_driver serialises to the display.
- Provides lap (display freeze) while the internal count keeps running.

Parameters:
- DEBOUNCE_W, 14, debounce counter width; a button must be stable for 2^DEBOUNCE_W clk cycles (16.4 ms at 1 MHz).
- SATURATE, 0, 0 = wrap 59:59.99 to 00:00.00; 1 = hold at 59:59.99.

Ports:
- clk  in  1  1 MHz system clock.
- res  in  1  asynchronous active-low reset.
- clk_div  in  1  100 Hz tick from the clock divider, synchronous to clk; each rising edge is one centisecond.
- btn_start_stop  in  1  raw push-button, active high, asynchronous.
- btn_lap_clear  in  1  raw push-button, active high, asynchronous.
- min_X0  out  3  displayed minutes tens (0-5).
- min_0X  out  4  displayed minutes units (0-9).
- sec_X0  out  3  displayed seconds tens (0-5).
- sec_0X  out  4  displayed seconds units (0-9).
- ces_X0  out  4  displayed centiseconds tens (0-9).
- ces_0X  out  4  displayed centiseconds units (0-9).
- running  out  1  high while counting; drives SPI_driver ena.
- overflow  out  1  sticky; set on wrap or saturation, cleared by clear.

Behaviour:
- Reset (res low, asynchronous): all digit outputs 0, running 0, overflow 0, state CLEARED, internal count 0, button conditioners idle.
- Button conditioning, per button:
  - 2-flop synchroniser, then debounce counter.
  - A new level is accepted only after 2^DEBOUNCE_W consecutive stable cycles.
  - A 1-cycle press pulse is produced on each accepted 0->1 transition. Releases produce nothing.
- Tick: tick = clk_div & ~clk_div_q, where clk_div_q is registered and resets to 0. Tick is therefore one cycle wide.
- Internal BCD counter, incremented on tick only in RUNNING and LAP:
  - ces_0X rolls 9->0 and carries to ces_X0.
  - ces_X0 rolls 9->0 and carries to sec_0X.
  - sec_0X rolls 9->0 and carries to sec_X0.
  - sec_X0 rolls 5->0 and carries to min_0X.
  - min_0X rolls 9->0 and carries to min_X0.
  - min_X0 at 5 with a carry in is the full-scale event:
    - SATURATE=0: all digits go to 0 and overflow is set.
    - SATURATE=1: the count holds at 59:59.99, overflow is set, further ticks are ignored.
  - Digit values are never outside their ranges above.
- Display register:
  - Follows the internal count, one cycle late, in CLEARED, RUNNING and PAUSED.
  - Frozen in LAP.
- FSM, with ss = start_stop press and lc = lap_clear press:
  - CLEARED: ss -> RUNNING. lc ignored.
  - RUNNING: ss -> PAUSED. lc -> LAP (display frozen at its current value).
  - LAP: ss -> PAUSED and display resumes (shows the paused count). lc -> RUNNING and display resumes.
  - PAUSED: ss -> RUNNING. lc -> CLEARED, which zeroes the count and display and clears overflow.
- Simultaneous ss and lc in the same cycle: ss wins and lc is dropped.
- Tick in the same cycle as the RUNNING->PAUSED transition: the tick is counted. The count stops from the next cycle.
- running = 1 in RUNNING and LAP; 0 otherwise.
- Reset asserted mid-count: immediate return to reset values, with no partial carry.

Decomposition:
- Package stopwatch_pkg:
  - FSM state encoding: CLEARED, RUNNING, PAUSED, LAP, 2 bits.
  - Digit limit constants: CES_MAX=9, SEC_TENS_MAX=5, MIN_TENS_MAX=5.
  - Digit width constants.
- Sub-module button_conditioner (params DEBOUNCE_W; ports clk, res, btn_raw, press): synchroniser, debounce and rise pulse. Instantiated twice.

Test Plan:
- Reset, then 10 ticks with no button -> all digits 0, running 0.
- Hold btn_start_stop stable 2^DEBOUNCE_W+3 cycles, then 123 ticks -> display 00:01.23, running 1.
- Bouncing start button (8 toggles, 100 cycles apart, then stable) -> exactly one press pulse and one state change.
- While running at 00:05.00, press lap, then 50 ticks -> display stays 00:05.00. Press lap again -> display 00:05.50.
- Preload to 59:59.99 via 359999 ticks, then 1 tick:
  - SATURATE=0 -> 00:00.00 and overflow 1.
  - SATURATE=1 -> holds at 59:59.99 and overflow 1.
- Paused at 00:42.17, press lap_clear -> 00:00.00, overflow 0, state CLEARED. Repeat with both buttons pressed the same cycle from PAUSED -> goes to RUNNING, count not cleared.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time base: FSM states,
// BCD digit widths/limits and the mm:ss.cc increment helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      CLEARED = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      LAP     = 2'd3
   } sw_state_e;

   localparam int MIN_T_W = 3;
   localparam int MIN_U_W = 4;
   localparam int SEC_T_W = 3;
   localparam int SEC_U_W = 4;
   localparam int CES_T_W = 4;
   localparam int CES_U_W = 4;

   localparam logic [3:0] UNIT_MAX     = 4'd9;
   localparam logic [3:0] CES_MAX      = 4'd9;
   localparam logic [2:0] SEC_TENS_MAX = 3'd5;
   localparam logic [2:0] MIN_TENS_MAX = 3'd5;

   typedef struct packed {
      logic [MIN_T_W-1:0] min_t;
      logic [MIN_U_W-1:0] min_u;
      logic [SEC_T_W-1:0] sec_t;
      logic [SEC_U_W-1:0] sec_u;
      logic [CES_T_W-1:0] ces_t;
      logic [CES_U_W-1:0] ces_u;
   } bcd_time_t;

   localparam bcd_time_t TIME_ZERO = '0;
   localparam bcd_time_t TIME_FULL = {MIN_TENS_MAX, UNIT_MAX, SEC_TENS_MAX, UNIT_MAX, CES_MAX, CES_MAX};

   // Ripple-carry BCD increment; full scale rolls every digit back to zero.
   function automatic bcd_time_t bcd_inc(input bcd_time_t t);
      bcd_time_t r;
      logic      c;
      r = t;
      c = 1'b1;
      if (t.ces_u == CES_MAX) r.ces_u = '0;
      else begin r.ces_u = t.ces_u + 4'd1; c = 1'b0; end
      if (c) begin
         if (t.ces_t == CES_MAX) r.ces_t = '0;
         else begin r.ces_t = t.ces_t + 4'd1; c = 1'b0; end
      end
      if (c) begin
         if (t.sec_u == UNIT_MAX) r.sec_u = '0;
         else begin r.sec_u = t.sec_u + 4'd1; c = 1'b0; end
      end
      if (c) begin
         if (t.sec_t == SEC_TENS_MAX) r.sec_t = '0;
         else begin r.sec_t = t.sec_t + 3'd1; c = 1'b0; end
      end
      if (c) begin
         if (t.min_u == UNIT_MAX) r.min_u = '0;
         else begin r.min_u = t.min_u + 4'd1; c = 1'b0; end
      end
      if (c) begin
         if (t.min_t == MIN_TENS_MAX) r.min_t = '0;
         else r.min_t = t.min_t + 3'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce counter and a
// one-cycle pulse on each accepted press; releases are accepted silently.
module button_conditioner #(
   parameter int DEBOUNCE_W = 14
) (
   input  logic clk,
   input  logic res,
   input  logic btn_raw,
   output logic press
);

   logic                  sync1_q, sync2_q;
   logic                  level_q, level_d;
   logic                  press_q, press_d;
   logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronised input disagrees with the accepted level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (&cnt_q) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + DEBOUNCE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: BCD mm:ss.cc counter under start/stop and lap/clear
// buttons, driving the six display digit buses of the SPI display driver.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_W = 14,
   parameter bit SATURATE   = 1'b0
) (
   input  logic               clk,
   input  logic               res,
   input  logic               clk_div,
   input  logic               btn_start_stop,
   input  logic               btn_lap_clear,
   output logic [MIN_T_W-1:0] min_X0,
   output logic [MIN_U_W-1:0] min_0X,
   output logic [SEC_T_W-1:0] sec_X0,
   output logic [SEC_U_W-1:0] sec_0X,
   output logic [CES_T_W-1:0] ces_X0,
   output logic [CES_U_W-1:0] ces_0X,
   output logic               running,
   output logic               overflow
);

   sw_state_e state_q, state_d;
   bcd_time_t cnt_q, cnt_d, disp_q, disp_d, cnt_inc;
   logic      clk_div_q, tick, ss_press, lc_press;
   logic      counting, clear_evt, at_full, ovf_q, ovf_d;

   button_conditioner #(.DEBOUNCE_W(DEBOUNCE_W)) u_btn_ss (
      .clk(clk), .res(res), .btn_raw(btn_start_stop), .press(ss_press)
   );

   button_conditioner #(.DEBOUNCE_W(DEBOUNCE_W)) u_btn_lc (
      .clk(clk), .res(res), .btn_raw(btn_lap_clear), .press(lc_press)
   );

   assign tick      = clk_div & ~clk_div_q;
   assign counting  = (state_q == RUNNING) || (state_q == LAP);
   assign clear_evt = (state_q == PAUSED) && lc_press && !ss_press;
   assign cnt_inc   = bcd_inc(cnt_q);
   assign at_full   = (cnt_q == TIME_FULL);

   // start/stop always has priority; a simultaneous lap/clear is dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEARED: if (ss_press) state_d = RUNNING;
         RUNNING: if (ss_press) state_d = PAUSED;  else if (lc_press) state_d = LAP;
         LAP:     if (ss_press) state_d = PAUSED;  else if (lc_press) state_d = RUNNING;
         PAUSED:  if (ss_press) state_d = RUNNING; else if (lc_press) state_d = CLEARED;
         default: state_d = CLEARED;
      endcase
   end

   // Ticks use the current state, so a tick coinciding with stop is still counted.
   always_comb begin
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      disp_d = disp_q;
      if (clear_evt) begin
         cnt_d = TIME_ZERO;
         ovf_d = 1'b0;
      end else if (tick && counting) begin
         if (at_full) begin
            ovf_d = 1'b1;
            if (!SATURATE) cnt_d = TIME_ZERO;
         end else begin
            cnt_d = cnt_inc;
         end
      end
      if (clear_evt) disp_d = TIME_ZERO;
      else if (state_q != LAP) disp_d = cnt_q;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q   <= CLEARED;
         cnt_q     <= TIME_ZERO;
         disp_q    <= TIME_ZERO;
         ovf_q     <= 1'b0;
         clk_div_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         disp_q    <= disp_d;
         ovf_q     <= ovf_d;
         clk_div_q <= clk_div;
      end
   end

   assign min_X0   = disp_q.min_t;
   assign min_0X   = disp_q.min_u;
   assign sec_X0   = disp_q.sec_t;
   assign sec_0X   = disp_q.sec_u;
   assign ces_X0   = disp_q.ces_t;
   assign ces_0X   = disp_q.ces_u;
   assign running  = counting;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: a wrapping and a saturating instance share stimulus;
// a centisecond-count model is compared every cycle, plus hand-computed literals.
module tb_stopwatch_counter;
   import stopwatch_pkg::*;

   localparam int DBW     = 4;
   localparam int DB_CYC  = 1 << DBW;
   localparam int FULL_CS = 359999;

   typedef enum int {M_CLR, M_RUN, M_PAU, M_LAP} mstate_t;

   logic clk = 1'b0;
   logic res, clk_div, btn_ss, btn_lc;
   logic [MIN_T_W-1:0] o_min_t [2];
   logic [MIN_U_W-1:0] o_min_u [2];
   logic [SEC_T_W-1:0] o_sec_t [2];
   logic [SEC_U_W-1:0] o_sec_u [2];
   logic [CES_T_W-1:0] o_ces_t [2];
   logic [CES_U_W-1:0] o_ces_u [2];
   logic               o_run   [2];
   logic               o_ovf   [2];

   mstate_t     m_state;
   int          m_cs  [2];
   int          m_frz [2];
   bit          m_ovf [2];
   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   logic [21:0] preload_v;
   bit          watch = 1'b0;
   int          pulses, falls, rises;
   logic        prev_run;

   always #5 clk = ~clk;

   stopwatch_counter #(.DEBOUNCE_W(DBW), .SATURATE(1'b0)) dut0 (
      .clk(clk), .res(res), .clk_div(clk_div),
      .btn_start_stop(btn_ss), .btn_lap_clear(btn_lc),
      .min_X0(o_min_t[0]), .min_0X(o_min_u[0]), .sec_X0(o_sec_t[0]), .sec_0X(o_sec_u[0]),
      .ces_X0(o_ces_t[0]), .ces_0X(o_ces_u[0]), .running(o_run[0]), .overflow(o_ovf[0])
   );

   stopwatch_counter #(.DEBOUNCE_W(DBW), .SATURATE(1'b1)) dut1 (
      .clk(clk), .res(res), .clk_div(clk_div),
      .btn_start_stop(btn_ss), .btn_lap_clear(btn_lc),
      .min_X0(o_min_t[1]), .min_0X(o_min_u[1]), .sec_X0(o_sec_t[1]), .sec_0X(o_sec_u[1]),
      .ces_X0(o_ces_t[1]), .ces_0X(o_ces_u[1]), .running(o_run[1]), .overflow(o_ovf[1])
   );

   function automatic logic [21:0] cs_to_bcd(input int cs);
      return {3'(cs / 60000), 4'((cs / 6000) % 10), 3'((cs / 1000) % 6),
              4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
   endfunction

   function automatic string fmt(input logic [21:0] t);
      return $sformatf("%0d%0d:%0d%0d.%0d%0d", t[21:19], t[18:15], t[14:12], t[11:8], t[7:4], t[3:0]);
   endfunction

   function automatic logic [21:0] obs(input int i);
      return {o_min_t[i], o_min_u[i], o_sec_t[i], o_sec_u[i], o_ces_t[i], o_ces_u[i]};
   endfunction

   function automatic int exp_disp(input int i);
      return (m_state == M_LAP) ? m_frz[i] : m_cs[i];
   endfunction

   task automatic chk_time(input string name, input logic [21:0] act, input logic [21:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %s expected %s at %0t", name, fmt(act), fmt(exp), $time);
      end
   endtask

   task automatic chk_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled away from the clock edge.
   always @(posedge clk) begin
      #2;
      if (chk_en && res) begin
         for (int i = 0; i < 2; i++) begin
            chk_time($sformatf("disp%0d", i), obs(i), cs_to_bcd(exp_disp(i)));
            chk_val($sformatf("running%0d", i), int'(o_run[i]), int'(m_state == M_RUN || m_state == M_LAP));
            chk_val($sformatf("overflow%0d", i), int'(o_ovf[i]), int'(m_ovf[i]));
         end
      end
   end

   always @(negedge clk) begin
      if (watch) begin
         if (dut0.u_btn_ss.press === 1'b1) pulses++;
         if (prev_run && !o_run[0]) falls++;
         if (!prev_run && o_run[0]) rises++;
         prev_run = o_run[0];
      end
   end

   function automatic bit m_counting();
      return (m_state == M_RUN) || (m_state == M_LAP);
   endfunction

   // Overflow shares the count register; the display lags the count by one cycle.
   task automatic do_tick();
      bit on;
      on = m_counting();
      clk_div = 1'b1;
      if (on) for (int i = 0; i < 2; i++) if (m_cs[i] == FULL_CS) m_ovf[i] = 1'b1;
      @(negedge clk);
      clk_div = 1'b0;
      if (on) begin
         for (int i = 0; i < 2; i++) begin
            if (m_cs[i] < FULL_CS) m_cs[i]++;
            else if (i == 0) m_cs[i] = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) do_tick();
      $display("ticks %0d state %s disp %s / %s", n, m_state.name(), fmt(obs(0)), fmt(obs(1)));
   endtask

   task automatic model_press(input bit ss, input bit lc);
      if (ss) begin
         case (m_state)
            M_CLR:   m_state = M_RUN;
            M_RUN:   m_state = M_PAU;
            M_LAP:   m_state = M_PAU;
            default: m_state = M_RUN;
         endcase
      end else if (lc) begin
         case (m_state)
            M_RUN: begin m_frz = m_cs; m_state = M_LAP; end
            M_LAP: m_state = M_RUN;
            M_PAU: begin
               m_state = M_CLR;
               for (int i = 0; i < 2; i++) begin m_cs[i] = 0; m_ovf[i] = 1'b0; end
            end
            default: m_state = M_CLR;
         endcase
      end
   endtask

   task automatic press(input bit ss, input bit lc);
      chk_en = 1'b0;
      btn_ss = ss;
      btn_lc = lc;
      repeat (DB_CYC + 8) @(negedge clk);
      btn_ss = 1'b0;
      btn_lc = 1'b0;
      repeat (DB_CYC + 8) @(negedge clk);
      model_press(ss, lc);
      chk_en = 1'b1;
      $display("press ss=%0d lc=%0d -> %s disp %s", ss, lc, m_state.name(), fmt(obs(0)));
   endtask

   task automatic press_ss_with_tick();
      bit found;
      chk_en = 1'b0;
      found  = 1'b0;
      btn_ss = 1'b1;
      for (int k = 0; k < 4 * DB_CYC && !found; k++) begin
         @(negedge clk);
         if (dut0.u_btn_ss.press === 1'b1) found = 1'b1;
      end
      chk_val("ss_pulse_seen", int'(found), 1);
      if (found) begin
         clk_div = 1'b1;
         @(negedge clk);
         clk_div = 1'b0;
         for (int i = 0; i < 2; i++) m_cs[i]++;
      end
      repeat (DB_CYC + 8) @(negedge clk);
      btn_ss = 1'b0;
      repeat (DB_CYC + 8) @(negedge clk);
      model_press(1'b1, 1'b0);
      chk_en = 1'b1;
      $display("stop with coincident tick -> %s disp %s", m_state.name(), fmt(obs(0)));
   endtask

   task automatic bounce_ss();
      chk_en   = 1'b0;
      pulses   = 0;
      falls    = 0;
      rises    = 0;
      prev_run = o_run[0];
      watch    = 1'b1;
      for (int k = 0; k < 8; k++) begin
         btn_ss = ~btn_ss;
         repeat (5) @(negedge clk);
      end
      btn_ss = 1'b1;
      repeat (DB_CYC + 8) @(negedge clk);
      btn_ss = 1'b0;
      repeat (DB_CYC + 8) @(negedge clk);
      watch = 1'b0;
      model_press(1'b1, 1'b0);
      chk_en = 1'b1;
      $display("bounced start: pulses %0d falls %0d rises %0d", pulses, falls, rises);
      chk_val("bounce_pulses", pulses, 1);
      chk_val("bounce_run_falls", falls, 1);
      chk_val("bounce_run_rises", rises, 0);
   endtask

   task automatic preload(input int cs);
      chk_en    = 1'b0;
      preload_v = cs_to_bcd(cs);
      force dut0.cnt_q = preload_v;
      force dut1.cnt_q = preload_v;
      repeat (2) @(negedge clk);
      release dut0.cnt_q;
      release dut1.cnt_q;
      for (int i = 0; i < 2; i++) m_cs[i] = cs;
      @(negedge clk);
      chk_en = 1'b1;
      $display("preload %s", fmt(preload_v));
   endtask

   task automatic chk_both(input string name, input logic [21:0] e0, input logic [21:0] e1);
      chk_time({name, "_0"}, obs(0), e0);
      chk_time({name, "_1"}, obs(1), e1);
   endtask

   initial begin
      res     = 1'b1;
      clk_div = 1'b0;
      btn_ss  = 1'b0;
      btn_lc  = 1'b0;
      m_state = M_CLR;
      for (int i = 0; i < 2; i++) begin m_cs[i] = 0; m_frz[i] = 0; m_ovf[i] = 1'b0; end
      #3 res = 1'b0;
      repeat (3) @(negedge clk);
      chk_both("reset_disp", 22'd0, 22'd0);
      chk_val("reset_running", int'(o_run[0]), 0);
      chk_val("reset_overflow", int'(o_ovf[1]), 0);
      res    = 1'b1;
      chk_en = 1'b1;

      ticks(10);
      chk_both("idle_ticks", 22'd0, 22'd0);
      press(1'b1, 1'b0);
      chk_val("start_running", int'(o_run[0]), 1);
      ticks(123);
      chk_both("t123", {3'd0, 4'd0, 3'd0, 4'd1, 4'd2, 4'd3}, {3'd0, 4'd0, 3'd0, 4'd1, 4'd2, 4'd3});
      ticks(377);
      chk_time("t500", obs(0), {3'd0, 4'd0, 3'd0, 4'd5, 4'd0, 4'd0});
      press(1'b0, 1'b1);
      ticks(50);
      chk_time("lap_frozen", obs(0), {3'd0, 4'd0, 3'd0, 4'd5, 4'd0, 4'd0});
      chk_val("lap_running", int'(o_run[0]), 1);
      press(1'b0, 1'b1);
      chk_time("lap_resume", obs(0), {3'd0, 4'd0, 3'd0, 4'd5, 4'd5, 4'd0});

      bounce_ss();
      chk_val("bounce_paused", int'(o_run[0]), 0);
      press(1'b1, 1'b0);
      ticks(3);
      press_ss_with_tick();
      chk_time("stop_tick_counted", obs(0), {3'd0, 4'd0, 3'd0, 4'd5, 4'd5, 4'd4});
      ticks(1);
      chk_time("paused_no_count", obs(0), {3'd0, 4'd0, 3'd0, 4'd5, 4'd5, 4'd4});

      press(1'b1, 1'b0);
      preload(5999);
      ticks(1);
      chk_time("carry_min", obs(0), {3'd0, 4'd1, 3'd0, 4'd0, 4'd0, 4'd0});
      preload(59999);
      ticks(1);
      chk_time("carry_min_tens", obs(1), {3'd1, 4'd0, 3'd0, 4'd0, 4'd0, 4'd0});
      preload(FULL_CS);
      chk_both("full_scale", {3'd5, 4'd9, 3'd5, 4'd9, 4'd9, 4'd9}, {3'd5, 4'd9, 3'd5, 4'd9, 4'd9, 4'd9});
      ticks(1);
      chk_both("full_tick", 22'd0, {3'd5, 4'd9, 3'd5, 4'd9, 4'd9, 4'd9});
      chk_val("wrap_overflow", int'(o_ovf[0]), 1);
      chk_val("sat_overflow", int'(o_ovf[1]), 1);
      ticks(1);
      chk_both("after_full", {3'd0, 4'd0, 3'd0, 4'd0, 4'd0, 4'd1}, {3'd5, 4'd9, 3'd5, 4'd9, 4'd9, 4'd9});

      press(1'b1, 1'b0);
      preload(4217);
      chk_time("paused_4217", obs(0), {3'd0, 4'd0, 3'd4, 4'd2, 4'd1, 4'd7});
      chk_val("ovf_before_clear", int'(o_ovf[0]), 1);
      press(1'b0, 1'b1);
      chk_both("cleared", 22'd0, 22'd0);
      chk_val("clear_ovf0", int'(o_ovf[0]), 0);
      chk_val("clear_ovf1", int'(o_ovf[1]), 0);
      chk_val("clear_running", int'(o_run[0]), 0);
      ticks(2);
      press(1'b0, 1'b1);

      press(1'b1, 1'b0);
      ticks(17);
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      chk_time("both_pressed", obs(0), {3'd0, 4'd0, 3'd0, 4'd0, 4'd1, 4'd7});
      chk_val("both_running", int'(o_run[0]), 1);
      ticks(3);
      chk_time("both_then_ticks", obs(1), {3'd0, 4'd0, 3'd0, 4'd0, 4'd2, 4'd0});

      preload(FULL_CS);
      ticks(6);
      chk_en  = 1'b0;
      clk_div = 1'b1;
      @(posedge clk);
      #1 res = 1'b0;
      #1;
      chk_both("midreset_disp", 22'd0, 22'd0);
      chk_val("midreset_running", int'(o_run[0]), 0);
      chk_val("midreset_ovf", int'(o_ovf[1]), 0);
      @(negedge clk);
      clk_div = 1'b0;
      @(negedge clk);
      res     = 1'b1;
      m_state = M_CLR;
      for (int i = 0; i < 2; i++) begin m_cs[i] = 0; m_ovf[i] = 1'b0; end
      chk_en = 1'b1;
      $display("mid-count reset released");
      ticks(2);
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
